// File: rtl/motor_pkg.sv
// motor_pkg: shared sizing for the motor PWM path.
// The controller and the decode monitor both size commands from here.
package motor_pkg;
  localparam int WIN_BITS = 10;
  localparam int MEAS_W   = WIN_BITS + 1;
  localparam int MEAS_MAX = (1 << WIN_BITS) - 1;
endpackage

// File: rtl/pwm_chan_decode.sv
// pwm_chan_decode: one wheel's fwd/rev duty measurement.
// Counts fwd-only, rev-only and overlap samples over one window.
module pwm_chan_decode
  import motor_pkg::*;
#(
  parameter int WB = WIN_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_fwd,
  input  logic        i_rev,
  input  logic        i_win_end,
  output logic [WB:0] o_meas,
  output logic        o_brake,
  output logic        o_part_overlap
);
  localparam int CW = WB + 1;
  localparam logic [CW-1:0] FULL =
    {1'b1, {WB{1'b0}}};
  localparam logic signed [CW:0] SMAX =
    {2'b00, {WB{1'b1}}};
  localparam logic signed [CW:0] SMIN =
    -SMAX;

  logic          r_s_fwd;
  logic          r_s_rev;
  logic [CW-1:0] r_fwd_cnt;
  logic [CW-1:0] r_rev_cnt;
  logic [CW-1:0] r_both_cnt;
  logic [WB:0]   r_meas;
  logic          r_brake;
  logic          r_part;

  logic          w_inc_fwd;
  logic          w_inc_rev;
  logic          w_inc_both;
  logic [CW-1:0] w_fwd_fin;
  logic [CW-1:0] w_rev_fin;
  logic [CW-1:0] w_both_fin;
  logic signed [CW:0] w_diff;
  logic [WB:0]   w_sat;
  logic          w_brake;
  logic          w_part;

  always_comb begin
    w_inc_fwd  = 1'b0;
    w_inc_rev  = 1'b0;
    w_inc_both = 1'b0;
    unique case (1'b1)
      (r_s_fwd & ~r_s_rev): w_inc_fwd  = 1'b1;
      (r_s_rev & ~r_s_fwd): w_inc_rev  = 1'b1;
      (r_s_fwd &  r_s_rev): w_inc_both = 1'b1;
      default: ;
    endcase
  end

  // Closing sample is folded in before the result is taken
  assign w_fwd_fin  = r_fwd_cnt
                    + {{WB{1'b0}}, w_inc_fwd};
  assign w_rev_fin  = r_rev_cnt
                    + {{WB{1'b0}}, w_inc_rev};
  assign w_both_fin = r_both_cnt
                    + {{WB{1'b0}}, w_inc_both};

  assign w_diff = $signed({1'b0, w_fwd_fin})
                - $signed({1'b0, w_rev_fin});

  always_comb begin
    w_sat = w_diff[WB:0];
    if (w_diff > SMAX) begin
      w_sat = SMAX[WB:0];
    end else if (w_diff < SMIN) begin
      w_sat = SMIN[WB:0];
    end
  end

  assign w_brake = (w_both_fin == FULL);
  assign w_part  = (w_both_fin != '0) && !w_brake;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_fwd    <= 1'b0;
      r_s_rev    <= 1'b0;
      r_fwd_cnt  <= '0;
      r_rev_cnt  <= '0;
      r_both_cnt <= '0;
      r_meas     <= '0;
      r_brake    <= 1'b0;
      r_part     <= 1'b0;
    end else begin
      r_s_fwd <= i_fwd;
      r_s_rev <= i_rev;
      if (i_win_end) begin
        r_fwd_cnt  <= '0;
        r_rev_cnt  <= '0;
        r_both_cnt <= '0;
        r_meas     <= w_brake ? '0 : w_sat;
        r_brake    <= w_brake;
        r_part     <= w_part;
      end else begin
        r_fwd_cnt  <= w_fwd_fin;
        r_rev_cnt  <= w_rev_fin;
        r_both_cnt <= w_both_fin;
      end
    end
  end

  assign o_meas         = r_meas;
  assign o_brake        = r_brake;
  assign o_part_overlap = r_part;
endmodule

// File: rtl/motor_pwm_decode.sv
// motor_pwm_decode: recovers signed wheel commands
// from the four motor PWM drive lines.
module motor_pwm_decode #(
  parameter int WIN_BITS = motor_pkg::WIN_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_fwd_lft,
  input  logic              i_rev_lft,
  input  logic              i_fwd_rht,
  input  logic              i_rev_rht,
  output logic [WIN_BITS:0] o_lft_meas,
  output logic [WIN_BITS:0] o_rht_meas,
  output logic              o_brake_lft,
  output logic              o_brake_rht,
  output logic              o_overlap_err,
  output logic              o_meas_vld
);
  logic [WIN_BITS-1:0] r_win_cnt;
  logic                r_meas_vld;
  logic                w_win_end;
  logic                w_ovl_lft;
  logic                w_ovl_rht;

  assign w_win_end = &r_win_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_cnt  <= '0;
      r_meas_vld <= 1'b0;
    end else begin
      r_win_cnt  <= r_win_cnt + WIN_BITS'(1);
      r_meas_vld <= w_win_end;
    end
  end

  pwm_chan_decode #(
    .WB (WIN_BITS)
  ) u_lft (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_fwd          (i_fwd_lft),
    .i_rev          (i_rev_lft),
    .i_win_end      (w_win_end),
    .o_meas         (o_lft_meas),
    .o_brake        (o_brake_lft),
    .o_part_overlap (w_ovl_lft)
  );

  pwm_chan_decode #(
    .WB (WIN_BITS)
  ) u_rht (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_fwd          (i_fwd_rht),
    .i_rev          (i_rev_rht),
    .i_win_end      (w_win_end),
    .o_meas         (o_rht_meas),
    .o_brake        (o_brake_rht),
    .o_part_overlap (w_ovl_rht)
  );

  assign o_overlap_err = w_ovl_lft | w_ovl_rht;
  assign o_meas_vld    = r_meas_vld;
endmodule
